// File: rtl/shared_reg_wr_arb_pkg.sv
// Shared definitions for the shared-register write arbiter.
// Holds the default requester count, data width and requester-index width,
// plus the rule for the smallest legal index width.
package shared_reg_wr_arb_pkg;

  localparam int DEF_N   = 4;
  localparam int DEF_W   = 8;
  localparam int DEF_IDW = 2;

  // The requester index must be able to name every requester.
  // In other words, IDW >= ceil(log2 N).
  function automatic int idw_min(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_wr_arb_reg_en_w.sv
// reg_en_w: W-bit bank of enable flip-flops.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset; clears q to 0
//   en  - 1 loads d on the next rising edge, 0 holds q
//   d   - load data
//   q   - register contents
module reg_en_w
  import shared_reg_wr_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shared_reg_wr_arb.sv
// shared_reg_wr_arb: round-robin write scheduler for one shared W-bit register.
// The block picks at most one requester per cycle. It loads that requester's
// data into the register. It then returns a one-cycle ack and records the
// winner as owner.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   req    - per-requester write request (level, held until acked)
//   wdata  - requester i's data is wdata[i*W +: W]
//   freeze - 1 suspends arbitration and writes this cycle
//   q      - current value of the shared register
//   ack    - one-hot, high for one cycle after the requester's write
//   upd    - high in the cycle after any write
//   owner  - index of the last requester that wrote q
module shared_reg_wr_arb
  import shared_reg_wr_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int W   = DEF_W,
  parameter int IDW = DEF_IDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  input  logic           freeze,
  output logic [W-1:0]   q,
  output logic [N-1:0]   ack,
  output logic           upd,
  output logic [IDW-1:0] owner
);

  logic [IDW-1:0] ptr;
  logic [N-1:0]   elig_p0;
  logic           found_p0;
  logic [IDW-1:0] winner_p0;
  logic           en_p0;
  logic [W-1:0]   wsel_p0;
  logic [N-1:0]   ack_nxt_p0;
  logic [IDW-1:0] ptr_nxt_p0;

  // Stage p0: combinational arbitration on the current requests and pointer.
  always_comb begin : p_arb
    int             idx;
    logic [IDW-1:0] sel;
    idx        = 0;
    sel        = '0;
    found_p0   = 1'b0;
    winner_p0  = '0;
    // A requester acked this cycle is masked. This stops a second write
    // while it is still dropping req.
    elig_p0    = req & ~ack;
    // Scan ptr, ptr+1, ... and wrap explicitly, so N need not be a power of two.
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      sel = IDW'(idx);
      if (!found_p0 && elig_p0[sel]) begin
        found_p0  = 1'b1;
        winner_p0 = sel;
      end
    end
    en_p0      = !freeze && found_p0;
    wsel_p0    = wdata[int'(winner_p0)*W +: W];
    ack_nxt_p0 = '0;
    ack_nxt_p0[winner_p0] = 1'b1;
    ptr_nxt_p0 = (int'(winner_p0) == N - 1) ? '0 : winner_p0 + IDW'(1);
  end

  // Stage p1: register the write, the ack/upd strobes, the owner and the pointer.
  reg_en_w #(.W(W)) u_q (
    .clk (clk),
    .rst (rst),
    .en  (en_p0),
    .d   (wsel_p0),
    .q   (q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack   <= '0;
      upd   <= 1'b0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      ack <= en_p0 ? ack_nxt_p0 : '0;
      upd <= en_p0;
      if (en_p0) begin
        owner <= winner_p0;
        ptr   <= ptr_nxt_p0;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_wr_arb.sv
// Directed testbench for shared_reg_wr_arb (N=4, W=8, IDW=2).
// Each step drives inputs 1 ns after a rising edge. Outputs are checked
// 1 ns after the next rising edge.
module tb_shared_reg_wr_arb;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic           freeze;
  logic [W-1:0]   q;
  logic [N-1:0]   ack;
  logic           upd;
  logic [IDW-1:0] owner;

  logic [W-1:0] wd [N];

  int errs;
  int checks;

  shared_reg_wr_arb #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wdata  (wdata),
    .freeze (freeze),
    .q      (q),
    .ack    (ack),
    .upd    (upd),
    .owner  (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      wdata[i*W +: W] = wd[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] eq, input logic [N-1:0] eack,
                           input logic eupd, input logic [IDW-1:0] eown);
    check({tag, ".q"},     32'(q),     32'(eq));
    check({tag, ".ack"},   32'(ack),   32'(eack));
    check({tag, ".upd"},   32'(upd),   32'(eupd));
    check({tag, ".owner"}, 32'(owner), 32'(eown));
  endtask

  logic [N-1:0]   cont_ack [5];
  logic [W-1:0]   cont_q   [5];
  logic [IDW-1:0] cont_own [5];

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b0;
    req    = '0;
    freeze = 1'b0;
    for (int i = 0; i < N; i++) wd[i] = '0;
    cont_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cont_q   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    cont_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    #1;
    check_all("reset", 8'h00, 4'b0000, 1'b0, 2'd0);
    tick();
    tick();
    rst = 1'b1;

    // Single write from requester 1; the ack cycle must not write again.
    wd[1] = 8'hA5;
    req   = 4'b0010;
    tick();
    check_all("single", 8'hA5, 4'b0010, 1'b1, 2'd1);
    wd[1] = 8'h3C;
    tick();
    check_all("single_hold", 8'hA5, 4'b0000, 1'b0, 2'd1);
    // ptr should now be 2: with 0 and 2 requesting, 2 wins.
    req   = 4'b0101;
    wd[0] = 8'h20;
    wd[2] = 8'h22;
    wd[3] = 8'h33;
    tick();
    check_all("ptr2", 8'h22, 4'b0100, 1'b1, 2'd2);
    // Wrap: ptr=3, req=1001 -> 3, then 0, then 3.
    req = 4'b1001;
    tick();
    check_all("wrap_a", 8'h33, 4'b1000, 1'b1, 2'd3);
    tick();
    check_all("wrap_b", 8'h20, 4'b0001, 1'b1, 2'd0);
    tick();
    check_all("wrap_c", 8'h33, 4'b1000, 1'b1, 2'd3);
    req = '0;
    tick();
    check_all("idle", 8'h33, 4'b0000, 1'b0, 2'd3);

    // Full contention from ptr=0.
    wd[0] = 8'h10;
    wd[1] = 8'h11;
    wd[2] = 8'h12;
    wd[3] = 8'h13;
    req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("cont%0d", i), cont_q[i], cont_ack[i], 1'b1, cont_own[i]);
    end

    // Freeze for 3 cycles; afterwards ptr=1 is served first.
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("frz%0d", i), 8'h10, 4'b0000, 1'b0, 2'd0);
    end
    freeze = 1'b0;
    tick();
    check_all("unfrz", 8'h11, 4'b0010, 1'b1, 2'd1);

    // Move ptr to 3, then req=0001 -> 0 wins and ptr becomes 1.
    req   = 4'b0100;
    wd[2] = 8'h42;
    tick();
    check_all("to_ptr3", 8'h42, 4'b0100, 1'b1, 2'd2);
    req   = 4'b0001;
    wd[0] = 8'h50;
    tick();
    check_all("wrap0", 8'h50, 4'b0001, 1'b1, 2'd0);
    req = '0;
    tick();
    req   = 4'b1001;
    wd[3] = 8'h63;
    tick();
    check_all("ptr1", 8'h63, 4'b1000, 1'b1, 2'd3);

    // Reset mid-operation: ptr=3 with 1001 pending restarts from 0.
    req   = 4'b0100;
    wd[2] = 8'h5A;
    tick();
    check_all("pre_rst", 8'h5A, 4'b0100, 1'b1, 2'd2);
    req   = 4'b1001;
    wd[0] = 8'h70;
    wd[3] = 8'h73;
    rst   = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 4'b0000, 1'b0, 2'd0);
    tick();
    check_all("in_rst", 8'h00, 4'b0000, 1'b0, 2'd0);
    rst = 1'b1;
    tick();
    check_all("post_rst_a", 8'h70, 4'b0001, 1'b1, 2'd0);
    tick();
    check_all("post_rst_b", 8'h73, 4'b1000, 1'b1, 2'd3);
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
